// File: rtl/console_tx_buffer_if.sv
// Byte-stream handshake bundle between the CPU output stream, the buffer and
// the JTAG UART input stream. The master side is whoever drives the upstream
// byte and the downstream consume strobe; the buffer itself is the slave.
interface console_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  in_canPeek;
    logic [7:0]            in_peek;
    logic                  in_consume_en;
    logic                  out_canPeek;
    logic [7:0]            out_peek;
    logic                  out_consume_en;
    logic [DEPTH_LOG2:0]   count;

    modport master (
        output in_canPeek,
        output in_peek,
        output out_consume_en,
        input  in_consume_en,
        input  out_canPeek,
        input  out_peek,
        input  count
    );

    modport slave (
        input  in_canPeek,
        input  in_peek,
        input  out_consume_en,
        output in_consume_en,
        output out_canPeek,
        output out_peek,
        output count
    );
endinterface

// File: rtl/console_tx_buffer.sv
// Elastic byte FIFO between the CPU character stream and the JTAG UART.
// Optionally expands each LF into CR LF on the way out; the CR is synthesised
// by the output state machine and never occupies a storage slot.
module console_tx_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter bit CRLF       = 1'b1
) (
    input  logic clock,
    input  logic reset,
    console_tx_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic {
        SEND    = 1'b0,
        LF_PEND = 1'b1
    } state_t;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    state_t                state_q;

    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       head_is_lf;
    logic       can_peek;
    logic       take;
    logic       push;
    logic       pop;
    logic       enter_lf;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Only an LF that is due for expansion needs the extra CR beat.
    assign head_is_lf = CRLF && (head == 8'h0A);

    // The pending LF is always presentable; otherwise we need a stored byte.
    assign can_peek = (state_q == LF_PEND) || !empty;
    assign take     = bus.out_consume_en && can_peek;

    // A real pop happens for plain bytes and for the LF half of an expansion;
    // taking the synthesised CR leaves the FIFO untouched.
    assign pop      = take && ((state_q == LF_PEND) || !head_is_lf);
    assign enter_lf = take && (state_q == SEND) && head_is_lf;

    // Accept upstream only when there is room; full stalls even while the
    // downstream pops, since nothing bypasses the storage.
    assign push = bus.in_canPeek && !full && reset;

    assign bus.in_consume_en = push;
    assign bus.out_canPeek   = can_peek;
    assign bus.count         = count_q;

    // Downstream byte: LF while expanding, CR in front of an LF, else the head.
    always_comb begin
        bus.out_peek = 8'h00;
        if (state_q == LF_PEND) begin
            bus.out_peek = 8'h0A;
        end else if (!empty) begin
            bus.out_peek = head_is_lf ? 8'h0D : head;
        end
    end

    // Pointer and occupancy next-state; simultaneous push and pop keeps count.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Output state machine plus pointers; reset discards buffered data and any pending LF.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= SEND;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                SEND: begin
                    if (enter_lf) begin
                        state_q <= LF_PEND;
                    end
                end
                LF_PEND: begin
                    if (pop) begin
                        state_q <= SEND;
                    end
                end
                default: state_q <= SEND;
            endcase
        end
    end

    // Byte storage; contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_peek;
        end
    end
endmodule

// File: tb/tb_console_tx_buffer.sv
// Directed bench for console_tx_buffer: a queue-based reference model is
// compared against the DUT every cycle, plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_console_tx_buffer;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    typedef logic [7:0] byte_q_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    console_tx_buffer_if #(.DEPTH_LOG2(DL2)) bus ();
    console_tx_buffer_if #(.DEPTH_LOG2(DL2)) bus0 ();

    console_tx_buffer #(.DEPTH_LOG2(DL2), .CRLF(1'b1)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    console_tx_buffer #(.DEPTH_LOG2(DL2), .CRLF(1'b0)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    int errors = 0;
    int checks = 0;

    // upstream sources, reference model and observation logs
    logic [7:0] src[$];
    logic [7:0] src0[$];
    logic [7:0] m_fifo[$];
    logic [7:0] exp_stream[$];
    logic [7:0] obs_log[$];
    logic [7:0] obs0[$];
    bit         m_pend = 1'b0;
    bit         take_flag = 1'b0;
    bit         take0 = 1'b0;
    int         cons_mode = 0;
    int         acc_cnt = 0;
    int         max_count = 0;

    logic       exp_can;
    logic       exp_take;
    logic [7:0] exp_peek;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic check_seq(input string name, input byte_q_t got, input byte_q_t exp);
        int n;
        check({name, "_len"}, got.size(), exp.size());
        n = (got.size() < exp.size()) ? got.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    // Model: stored bytes in a queue, pending-LF flag, and the expected output stream.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_consume", bus.in_consume_en, 0);
            check("rst_out_canPeek", bus.out_canPeek, 0);
            check("rst_out_peek", bus.out_peek, 0);
            check("rst_count", bus.count, 0);
            take_flag = 1'b0;
        end else begin
            exp_can  = m_pend || (m_fifo.size() > 0);
            exp_peek = 8'h00;
            if (m_pend)                    exp_peek = 8'h0A;
            else if (m_fifo.size() > 0)    exp_peek = (m_fifo[0] == 8'h0A) ? 8'h0D : m_fifo[0];
            exp_take = bus.in_canPeek && (m_fifo.size() < DEPTH);

            check("in_consume_en", bus.in_consume_en, exp_take);
            check("out_canPeek", bus.out_canPeek, exp_can);
            check("count", bus.count, m_fifo.size());
            if (exp_can) check("out_peek", bus.out_peek, exp_peek);
            if (int'(bus.count) > max_count) max_count = int'(bus.count);

            if (exp_can && bus.out_consume_en) begin
                obs_log.push_back(bus.out_peek);
                if (exp_stream.size() == 0) check("sb_extra_byte", bus.out_peek, -1);
                else                        check("sb_byte", bus.out_peek, exp_stream.pop_front());
                if (m_pend) begin
                    m_pend = 1'b0;
                    void'(m_fifo.pop_front());
                end else if (m_fifo[0] == 8'h0A) begin
                    m_pend = 1'b1;
                end else begin
                    void'(m_fifo.pop_front());
                end
            end
            if (exp_take) begin
                m_fifo.push_back(bus.in_peek);
                if (bus.in_peek == 8'h0A) begin
                    exp_stream.push_back(8'h0D);
                    exp_stream.push_back(8'h0A);
                end else begin
                    exp_stream.push_back(bus.in_peek);
                end
                acc_cnt++;
            end
            take_flag = bus.in_consume_en;
        end
    end

    // Asynchronous reset empties the model along with the DUT.
    always @(negedge rst_n) begin
        m_fifo.delete();
        exp_stream.delete();
        m_pend    = 1'b0;
        take_flag = 1'b0;
        take0     = 1'b0;
    end

    // Upstream/downstream driver for the CRLF instance.
    always @(posedge clk) begin
        #1;
        if (take_flag && src.size() > 0) void'(src.pop_front());
        take_flag = 1'b0;
        bus.in_canPeek     = (src.size() > 0);
        bus.in_peek        = (src.size() > 0) ? src[0] : 8'h00;
        bus.out_consume_en = (cons_mode == 1) || (cons_mode == 2 && $urandom_range(0, 1) == 1);
    end

    // Observer and driver for the pass-through instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.out_canPeek && bus0.out_consume_en) obs0.push_back(bus0.out_peek);
            take0 = bus0.in_consume_en;
        end
    end

    always @(posedge clk) begin
        #1;
        if (take0 && src0.size() > 0) void'(src0.pop_front());
        take0 = 1'b0;
        bus0.in_canPeek     = (src0.size() > 0);
        bus0.in_peek        = (src0.size() > 0) ? src0[0] : 8'h00;
        bus0.out_consume_en = 1'b1;
    end

    task automatic wait_drain(input string name, input int maxc);
        int n = 0;
        while (!(src.size() == 0 && m_fifo.size() == 0 && !m_pend) && n < maxc) begin
            @(posedge clk);
            n++;
        end
        check({name, "_timeout"}, (n < maxc) ? 1 : 0, 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t  exp_q;
        logic [7:0] b;
        int       nlf;

        bus.in_canPeek      = 1'b0;
        bus.in_peek         = 8'h00;
        bus.out_consume_en  = 1'b0;
        bus0.in_canPeek     = 1'b0;
        bus0.in_peek        = 8'h00;
        bus0.out_consume_en = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // 1: stream A B C with constant consume
        max_count = 0;
        obs_log.delete();
        src = {8'h41, 8'h42, 8'h43};
        cons_mode = 1;
        wait_drain("t1", 50);
        exp_q = {8'h41, 8'h42, 8'h43};
        check_seq("t1_out", obs_log, exp_q);
        check("t1_max_count_le1", (max_count <= 1) ? 1 : 0, 1);

        // 2: fill with 20 bytes, no consume; then drain
        cons_mode = 0;
        obs_log.delete();
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) src.push_back(8'h60 + 8'(i));
        repeat (25) @(posedge clk);
        #2;
        check("t2_accepted", acc_cnt, 16);
        check("t2_count_full", bus.count, 16);
        check("t2_in_stalled", bus.in_consume_en, 0);
        check("t2_src_left", src.size(), 4);
        cons_mode = 1;
        wait_drain("t2", 100);
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back(8'h60 + 8'(i));
        check_seq("t2_out", obs_log, exp_q);

        // 3: CRLF expansion, and the pass-through instance on the same input
        obs_log.delete();
        src  = {8'h48, 8'h0A, 8'h49};
        src0 = {8'h48, 8'h0A, 8'h49};
        wait_drain("t3", 50);
        repeat (4) @(posedge clk);
        #2;
        exp_q = {8'h48, 8'h0D, 8'h0A, 8'h49};
        check_seq("t3_crlf_out", obs_log, exp_q);
        exp_q = {8'h48, 8'h0A, 8'h49};
        check_seq("t3_raw_out", obs0, exp_q);
        check("t3_raw_count", bus0.count, 0);

        // 4: back-pressure while the LF is pending, upstream keeps filling
        cons_mode = 0;
        obs_log.delete();
        src = {8'h0A, 8'h31, 8'h32};
        repeat (6) @(posedge clk);
        #2;
        check("t4_count3", bus.count, 3);
        cons_mode = 1;
        @(posedge clk);
        #2;
        cons_mode = 0;
        src.push_back(8'h33);
        src.push_back(8'h34);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            check("t4_lf_canPeek", bus.out_canPeek, 1);
            check("t4_lf_peek", bus.out_peek, 8'h0A);
        end
        check("t4_count5", bus.count, 5);
        exp_q = {8'h0D};
        check_seq("t4_cr_only", obs_log, exp_q);

        // 5: asynchronous reset between edges in LF_PEND with count 5
        rst_n = 1'b0;
        #1;
        check("t5_async_canPeek", bus.out_canPeek, 0);
        check("t5_async_count", bus.count, 0);
        check("t5_async_peek", bus.out_peek, 0);
        check("t5_async_in_consume", bus.in_consume_en, 0);
        src.delete();
        obs_log.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        src = {8'h55, 8'h66};
        cons_mode = 1;
        wait_drain("t5", 50);
        exp_q = {8'h55, 8'h66};
        check_seq("t5_after_reset", obs_log, exp_q);

        // 6: 100 random bytes with random consume, wrapping the pointers
        obs_log.delete();
        nlf = 0;
        for (int i = 0; i < 100; i++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom_range(0, 255));
            if (b == 8'h0A) nlf++;
            src.push_back(b);
        end
        cons_mode = 2;
        wait_drain("t6", 3000);
        check("t6_out_len", obs_log.size(), 100 + nlf);
        check("t6_count_end", bus.count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
